// File: rtl/slc3_test_top.sv
// slc3_test_top - SLC-3 (16-bit LC-3 subset) CPU with 256-word preloaded
// memory and a memory-mapped switch/display port at xFFFF.
//
// Ports:
//   Clk        system clock, rising edge
//   Run        active-low button, starts execution from Halted
//   Continue   active-low button, resumes from PAUSE
//              (Run and Continue both low = asynchronous reset)
//   SW[9:0]    switches, read at xFFFF (zero-extended)
//   LED[9:0]   IR[9:0] while paused, otherwise 0
//   HEX0..HEX3 active-low {g,f,e,d,c,b,a} segments of HexReg, HEX3 = MS nibble
module slc3_test_top (
  input  logic       Clk,
  input  logic       Run,
  input  logic       Continue,
  input  logic [9:0] SW,
  output logic [9:0] LED,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam logic [4:0] S_HALTED = 5'd0;
  localparam logic [4:0] S_FETCH1 = 5'd1;
  localparam logic [4:0] S_FETCH2 = 5'd2;
  localparam logic [4:0] S_FETCH3 = 5'd3;
  localparam logic [4:0] S_FETCH4 = 5'd4;
  localparam logic [4:0] S_DECODE = 5'd5;
  localparam logic [4:0] S_EXEC   = 5'd6;
  localparam logic [4:0] S_LDR1   = 5'd7;
  localparam logic [4:0] S_LDR2   = 5'd8;
  localparam logic [4:0] S_LDR3   = 5'd9;
  localparam logic [4:0] S_LDR4   = 5'd10;
  localparam logic [4:0] S_STR1   = 5'd11;
  localparam logic [4:0] S_STR2   = 5'd12;
  localparam logic [4:0] S_STR3   = 5'd13;
  localparam logic [4:0] S_PAUSEA = 5'd14;
  localparam logic [4:0] S_PAUSEB = 5'd15;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  // Test image: bootstrap at x0000, I/O loop at x0006, ALU/branch program
  // at x0010 (constant at x001F), JSR program at x0020.
  function automatic logic [255:0][15:0] build_image();
    logic [255:0][15:0] img;
    img = '0;
    img[8'h00] = 16'h5020;  // AND R0,R0,#0
    img[8'h01] = 16'h623F;  // LDR R1,R0,#-1   (switches)
    img[8'h02] = 16'hC040;  // JMP R1
    img[8'h06] = 16'hD006;  // PAUSE
    img[8'h07] = 16'h643F;  // LDR R2,R0,#-1
    img[8'h08] = 16'h743F;  // STR R2,R0,#-1   (display)
    img[8'h09] = 16'h0FFC;  // BRnzp x0006
    img[8'h10] = 16'h661F;  // LDR R3,R0,#31   (x7FFF)
    img[8'h11] = 16'h18E1;  // ADD R4,R3,#1
    img[8'h12] = 16'h0801;  // BRn x0014
    img[8'h13] = 16'h5920;  // AND R4,R4,#0
    img[8'h14] = 16'h783F;  // STR R4,R0,#-1
    img[8'h15] = 16'h0401;  // BRz x0017
    img[8'h16] = 16'hD016;  // PAUSE
    img[8'h17] = 16'h1B04;  // ADD R5,R4,R4
    img[8'h18] = 16'h7A3F;  // STR R5,R0,#-1
    img[8'h19] = 16'h0401;  // BRz x001B
    img[8'h1A] = 16'hD01A;  // PAUSE
    img[8'h1B] = 16'h9D7F;  // NOT R6,R5
    img[8'h1C] = 16'h7C3F;  // STR R6,R0,#-1
    img[8'h1D] = 16'hD01D;  // PAUSE
    img[8'h1E] = 16'h0FFF;  // BRnzp x001E
    img[8'h1F] = 16'h7FFF;
    img[8'h20] = 16'h4802;  // JSR x0023
    img[8'h23] = 16'h7E3F;  // STR R7,R0,#-1
    img[8'h24] = 16'hD024;  // PAUSE
    img[8'h25] = 16'h0FFF;  // BRnzp x0025
    return img;
  endfunction

  localparam logic [255:0][15:0] IMAGE = build_image();

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    return {v[15], (v == 16'h0000), (!v[15] && (v != 16'h0000))};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic              rst_n;
  logic [4:0]        state_q, state_d;
  logic [15:0]       pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [15:0]       hex_q, hex_d;
  logic [7:0][15:0]  regs_q, regs_d;
  logic [2:0]        nzp_q, nzp_d;
  logic              ram_we;
  logic [15:0]       ram_rdata;
  logic [15:0]       mem_delta [256];

  logic [3:0]  opcode;
  logic [15:0] sr1_val, sr2_val, dr_val, alu_b, alu_res, mem_rdata;
  logic [15:0] imm5, off6, off9, off11;

  always_comb rst_n = Run | Continue;

  always_comb begin
    opcode  = ir_q[15:12];
    sr1_val = regs_q[ir_q[8:6]];
    sr2_val = regs_q[ir_q[2:0]];
    dr_val  = regs_q[ir_q[11:9]];
    imm5    = {{11{ir_q[4]}}, ir_q[4:0]};
    off6    = {{10{ir_q[5]}}, ir_q[5:0]};
    off9    = {{7{ir_q[8]}}, ir_q[8:0]};
    off11   = {{5{ir_q[10]}}, ir_q[10:0]};
    alu_b   = ir_q[5] ? imm5 : sr2_val;
    case (opcode)
      OP_ADD:  alu_res = sr1_val + alu_b;
      OP_AND:  alu_res = sr1_val & alu_b;
      default: alu_res = ~sr1_val;
    endcase
    if (mar_q == 16'hFFFF)        mem_rdata = {6'b0, SW};
    else if (mar_q[15:8] == 8'h00) mem_rdata = ram_rdata;
    else                           mem_rdata = '0;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    hex_d   = hex_q;
    regs_d  = regs_q;
    nzp_d   = nzp_q;
    ram_we  = 1'b0;
    case (state_q)
      S_HALTED: if (!Run) state_d = S_FETCH1;
      S_FETCH1: begin
        mar_d   = pc_q;
        pc_d    = pc_q + 16'd1;
        state_d = S_FETCH2;
      end
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: begin
        mdr_d   = mem_rdata;
        state_d = S_FETCH4;
      end
      S_FETCH4: begin
        ir_d    = mdr_q;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LDR:   state_d = S_LDR1;
          OP_STR:   state_d = S_STR1;
          OP_PAUSE: state_d = S_PAUSEA;
          default:  state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            regs_d[ir_q[11:9]] = alu_res;
            nzp_d              = nzp_of(alu_res);
          end
          OP_BR:  if (|(ir_q[11:9] & nzp_q)) pc_d = pc_q + off9;
          OP_JMP: pc_d = sr1_val;
          OP_JSR: begin
            regs_d[7] = pc_q;
            pc_d      = pc_q + off11;
          end
          default: ;
        endcase
        state_d = S_FETCH1;
      end
      S_LDR1: begin
        mar_d   = sr1_val + off6;
        state_d = S_LDR2;
      end
      S_LDR2: state_d = S_LDR3;
      S_LDR3: begin
        mdr_d   = mem_rdata;
        state_d = S_LDR4;
      end
      S_LDR4: begin
        regs_d[ir_q[11:9]] = mdr_q;
        nzp_d              = nzp_of(mdr_q);
        state_d            = S_FETCH1;
      end
      S_STR1: begin
        mar_d   = sr1_val + off6;
        state_d = S_STR2;
      end
      S_STR2: begin
        mdr_d   = dr_val;
        state_d = S_STR3;
      end
      S_STR3: begin
        if (mar_q == 16'hFFFF) hex_d = mdr_q;
        ram_we  = (mar_q[15:8] == 8'h00);
        state_d = S_FETCH1;
      end
      // Two-phase pause: press moves to B, release leaves, so a held
      // button resumes exactly once.
      S_PAUSEA: if (!Continue) state_d = S_PAUSEB;
      S_PAUSEB: if (Continue)  state_d = S_FETCH1;
      default:  state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALTED;
      pc_q    <= '0;
      ir_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      hex_q   <= '0;
      regs_q  <= '0;
      nzp_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      hex_q   <= hex_d;
      regs_q  <= regs_d;
      nzp_q   <= nzp_d;
    end
  end

  // Memory survives reset. The array powers up cleared, so each word is
  // stored XOR'ed with its image value: an untouched word reads back as
  // the preloaded program without any load sequence.
  always_ff @(posedge Clk) begin
    if (ram_we) mem_delta[mar_q[7:0]] <= mdr_q ^ IMAGE[mar_q[7:0]];
    ram_rdata <= mem_delta[mar_q[7:0]] ^ IMAGE[mar_q[7:0]];
  end

  always_comb begin
    LED  = ((state_q == S_PAUSEA) || (state_q == S_PAUSEB)) ? ir_q[9:0] : '0;
    HEX0 = seg7(hex_q[3:0]);
    HEX1 = seg7(hex_q[7:4]);
    HEX2 = seg7(hex_q[11:8]);
    HEX3 = seg7(hex_q[15:12]);
  end

endmodule

// File: tb/tb_slc3_test_top.sv
// Directed bench for slc3_test_top: reset, bootstrap, switch/display loop,
// held Continue, ALU/branch program, JSR program and reset mid-LDR.
module tb_slc3_test_top;

  logic       Clk = 1'b0;
  logic       Run = 1'b1;
  logic       Continue = 1'b1;
  logic [9:0] SW = '0;
  logic [9:0] LED;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] HALTED = 5'd0;

  slc3_test_top dut (
    .Clk(Clk), .Run(Run), .Continue(Continue), .SW(SW), .LED(LED),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [31:0] disp(input logic [15:0] v);
    return {4'h0, seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
  endfunction

  function automatic logic [31:0] hexbus();
    return {4'h0, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Run = 1'b0; Continue = 1'b0;
    @(negedge Clk);
    Run = 1'b1; Continue = 1'b1;
  endtask

  task automatic pulse_run();
    @(negedge Clk); Run = 1'b0;
    @(negedge Clk); Run = 1'b1;
  endtask

  task automatic pulse_cont();
    @(negedge Clk); Continue = 1'b0;
    @(negedge Clk); Continue = 1'b1;
  endtask

  // Leave the current pause (if any), then wait for the next one.
  task automatic wait_pause(input string tag, input int max);
    int n;
    n = 0;
    while (LED != 10'd0 && n < max) begin @(negedge Clk); n++; end
    while (LED == 10'd0 && n < max) begin @(negedge Clk); n++; end
    chk(tag, 32'(LED != 10'd0), 32'd1);
  endtask

  initial begin
    logic [9:0] io_vals [3];
    io_vals = '{10'd4, 10'd1, 10'd5};

    // Reset
    @(negedge Clk);
    Run = 1'b0; Continue = 1'b0;
    #1;
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_hex", hexbus(), disp(16'h0000));
    chk("rst_pc", 32'(dut.pc_q), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(HALTED));
    @(negedge Clk);
    Run = 1'b1; Continue = 1'b1;
    repeat (5) @(negedge Clk);
    chk("idle_state", 32'(dut.state_q), 32'(HALTED));
    chk("idle_pc", 32'(dut.pc_q), 32'h0);

    // Bootstrap to x0006
    SW = 10'h006;
    pulse_run();
    wait_pause("boot_timeout", 30);
    chk("boot_led", 32'(LED), 32'h006);
    chk("boot_pc", 32'(dut.pc_q), 32'h0007);
    chk("boot_hex", hexbus(), disp(16'h0000));

    // Switch -> display loop, one pass per press
    for (int i = 0; i < 3; i++) begin
      SW = io_vals[i];
      pulse_cont();
      wait_pause("io_timeout", 60);
      chk("io_hex", hexbus(), disp({6'b0, io_vals[i]}));
      chk("io_led", 32'(LED), 32'h006);
    end

    // Held Continue: nothing runs while held, one pass after release
    SW = 10'd7;
    @(negedge Clk); Continue = 1'b0;
    repeat (40) @(negedge Clk);
    chk("hold_led", 32'(LED), 32'h006);
    chk("hold_pc", 32'(dut.pc_q), 32'h0007);
    chk("hold_hex", hexbus(), disp(16'h0005));
    SW = 10'd2;
    repeat (20) @(negedge Clk);
    Continue = 1'b1;
    wait_pause("hold_timeout", 60);
    chk("hold_rel_hex", hexbus(), disp(16'h0002));
    repeat (40) @(negedge Clk);
    chk("hold_once_pc", 32'(dut.pc_q), 32'h0007);
    chk("hold_once_led", 32'(LED), 32'h006);

    // ALU / branch program at x0010
    do_reset();
    SW = 10'h010;
    pulse_run();
    wait_pause("alu_timeout", 120);
    chk("alu_led", 32'(LED), 32'h016);
    chk("alu_hex", hexbus(), disp(16'h8000));
    chk("alu_nzp", 32'(dut.nzp_q), 32'b100);
    pulse_cont();
    wait_pause("alu2_timeout", 80);
    chk("alu2_led", 32'(LED), 32'h01D);
    chk("alu2_hex", hexbus(), disp(16'hFFFF));
    chk("alu2_r5", 32'(dut.regs_q[5]), 32'h0000);

    // JSR program at x0020
    do_reset();
    SW = 10'h020;
    pulse_run();
    wait_pause("jsr_timeout", 80);
    chk("jsr_led", 32'(LED), 32'h024);
    chk("jsr_hex", hexbus(), disp(16'h0021));

    // Reset in the middle of the loop's LDR, then re-run
    do_reset();
    SW = 10'h006;
    pulse_run();
    wait_pause("ldr_boot_timeout", 40);
    SW = 10'd9;
    pulse_cont();
    wait_pause("ldr_first_timeout", 60);
    chk("ldr_first_hex", hexbus(), disp(16'h0009));
    pulse_cont();
    repeat (7) @(negedge Clk);
    chk("ldr_mid_pc", 32'(dut.pc_q), 32'h0008);
    chk("ldr_mid_led", 32'(LED), 32'h0);
    #2;
    Run = 1'b0; Continue = 1'b0;
    #1;
    chk("ldr_rst_pc", 32'(dut.pc_q), 32'h0);
    chk("ldr_rst_state", 32'(dut.state_q), 32'(HALTED));
    chk("ldr_rst_r1", 32'(dut.regs_q[1]), 32'h0);
    chk("ldr_rst_hex", hexbus(), disp(16'h0000));
    @(negedge Clk);
    Run = 1'b1; Continue = 1'b1;
    SW = 10'h006;
    pulse_run();
    wait_pause("rerun_boot_timeout", 40);
    SW = 10'd9;
    pulse_cont();
    wait_pause("rerun_timeout", 60);
    chk("rerun_hex", hexbus(), disp(16'h0009));
    chk("rerun_led", 32'(LED), 32'h006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
